corr_frame_sequencer: RTL and testbench
=======================================

Name: corr_frame_sequencer

Overview:
- Sequences paired sample streams into the correlation wrapper: joins the sig1 and sig2 AXI-Stream sources, forwards them in lockstep, and frames the sig2 stream with tlast every frame_len samples.
- Enforces a programmable inter-frame gap so the correlator can finish each frame.
- Counts frames, stops after num_frames, and reports status to the control plane.

Parameters:
- DATA_W, 16, sample width of both streams.
- CNT_W, 16, width of frame_len, num_frames and internal counters.
- GAP_CYCLES, 16, idle cycles inserted after each frame's tlast handshake; 0 means no gap.

Ports:
- sclk  in  1  system clock
- areset  in  1  asynchronous reset, active-high
- start  in  1  one-cycle pulse; accepted only in IDLE
- stop  in  1  one-cycle pulse; graceful stop request
- frame_len  in  CNT_W  samples per frame; latched at start
- num_frames  in  CNT_W  frames to run; 0 = continuous; latched at start
- s1_axis_tdata  in  DATA_W  source sig1 data
- s1_axis_tvalid  in  1  source sig1 valid
- s1_axis_tready  out  1  source sig1 ready
- s2_axis_tdata  in  DATA_W  source sig2 data
- s2_axis_tvalid  in  1  source sig2 valid
- s2_axis_tready  out  1  source sig2 ready
- sig1_axis_tdata/tvalid  out  DATA_W/1  to correlator sig1
- sig1_axis_tready  in  1  from correlator
- sig2_axis_tdata/tvalid/tlast  out  DATA_W/1/1  to correlator sig2
- sig2_axis_tready  in  1  from correlator
- busy  out  1  high in RUN or GAP
- done  out  1  one-cycle pulse on normal completion
- len_err  out  1  one-cycle pulse when start is given with frame_len==0
- frame_cnt  out  CNT_W  frames completed since last start

Behaviour:
- Reset:
  - State = IDLE.
  - All outputs 0: tvalids, tlast, treadys, busy, done, len_err, frame_cnt.
  - Internal counters cleared.
  - Reset mid-operation discards any held sample pair.
- Output stage:
  - One-entry pair register with independent valid bits v1 and v2.
  - sig1_axis_tvalid = v1; sig2_axis_tvalid = v2.
  - Each bit clears on its own handshake.
  - Output valids never depend on the downstream tready.
- Slot and load rules:
  - Slot free = (!v1 or sig1 handshake this cycle) and (!v2 or sig2 handshake this cycle).
  - s1_axis_tready = s2_axis_tready = (state==RUN) & s1_axis_tvalid & s2_axis_tvalid & slot free.
  - The two sources always transfer in the same cycle; no sample from either side is dropped or duplicated.
  - On load: v1 = v2 = 1, data registered, tlast registered = (sample_idx == frame_len_q-1).
- FSM states: IDLE, RUN, GAP.
  - IDLE, start with frame_len==0: pulse len_err, stay IDLE.
  - IDLE, start with frame_len!=0:
    - Latch frame_len and num_frames.
    - Clear sample_idx, frame_cnt and stop_pend.
    - Go to RUN next cycle.
  - RUN, load with tlast:
    - sample_idx wraps to 0; frame_cnt increments.
    - Go to GAP, or directly to the end check if GAP_CYCLES==0.
  - Other loads in RUN: sample_idx increments.
  - GAP:
    - Waits until the held pair has fully drained (v1==v2==0), then counts GAP_CYCLES cycles.
    - Then: if stop_pend, or num_frames!=0 and frame_cnt==num_frames, go to IDLE and pulse done; otherwise go to RUN.
- Stop handling:
  - stop sets stop_pend in RUN or GAP; the current frame always completes with tlast.
  - stop in IDLE is ignored.
  - done is also pulsed on a stop-terminated completion.
- Simultaneous events:
  - start+stop in IDLE: start wins and stop is ignored.
  - start while busy: ignored.
- Arithmetic: frame_cnt saturates at all-ones in continuous mode; it does not wrap.

Decomposition:
- Shared package corr_pkg:
  - DATA_W and CNT_W defaults.
  - FSM state encoding (IDLE=0, RUN=1, GAP=2).
- Sub-module corr_pair_slot: the two-valid-bit output register with its load/drain logic.
- corr_frame_sequencer instantiates corr_pair_slot and holds the FSM and counters.

Test Plan:
- Basic frame: frame_len=4, num_frames=2, GAP_CYCLES=3, sources always valid, sinks always ready.
  - 8 pairs delivered; tlast on pairs 4 and 8.
  - At least 3 idle cycles between the frames.
  - frame_cnt ends at 2; one done pulse; busy low after.
- Skewed sources: s2 tvalid low for 5 cycles mid-frame while s1 stays valid.
  - No s1 transfers during those cycles.
  - Output order is identical to the input order; no data loss.
- Independent backpressure: sig1_axis_tready low for 3 cycles while sig2_axis_tready stays high.
  - v2 drains, v1 is held, no new load occurs.
  - sig1 data stays stable until its handshake.
- Stop mid-frame: frame_len=10, num_frames=0, stop after 3 samples.
  - Frame completes at sample 10 with tlast, then gap.
  - IDLE, done pulse, frame_cnt=1.
- Zero length: start with frame_len=0.
  - len_err pulses one cycle; stays IDLE; treadys stay 0.
- Async reset during RUN with a held pair: all valids, tlast and busy drop immediately; a fresh start then runs normally.

Source files
------------

// File: rtl/corr_pkg.sv
// Shared widths and FSM encoding for the correlator frame sequencer.
// The pair slot and the sequencer top both import this package.
package corr_pkg;

  localparam int DATA_W_DEF = 16;
  localparam int CNT_W_DEF  = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

endpackage

// File: rtl/corr_pair_slot.sv
// One-entry output register for a sig1/sig2 sample pair.
// Each side has its own valid bit and drains on its own handshake.
module corr_pair_slot import corr_pkg::*; #(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [DATA_W-1:0] load_data1,
  input  logic [DATA_W-1:0] load_data2,
  input  logic              load_last,
  input  logic              ready1,
  input  logic              ready2,
  output logic [DATA_W-1:0] data1,
  output logic              valid1,
  output logic [DATA_W-1:0] data2,
  output logic              valid2,
  output logic              last,
  output logic              free,
  output logic              empty
);

  logic [DATA_W-1:0] data1_reg;
  logic [DATA_W-1:0] data2_reg;
  logic              v1_reg;
  logic              v2_reg;
  logic              last_reg;

  // A side is reusable this cycle if it is empty or is being taken now.
  assign free  = (!v1_reg || ready1) && (!v2_reg || ready2);
  assign empty = !v1_reg && !v2_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data1_reg <= '0;
      data2_reg <= '0;
      v1_reg    <= 1'b0;
      v2_reg    <= 1'b0;
      last_reg  <= 1'b0;
    end else if (load) begin
      data1_reg <= load_data1;
      data2_reg <= load_data2;
      v1_reg    <= 1'b1;
      v2_reg    <= 1'b1;
      last_reg  <= load_last;
    end else begin
      if (v1_reg && ready1) v1_reg <= 1'b0;
      if (v2_reg && ready2) v2_reg <= 1'b0;
    end
  end

  assign data1  = data1_reg;
  assign data2  = data2_reg;
  assign valid1 = v1_reg;
  assign valid2 = v2_reg;
  assign last   = last_reg && v2_reg;

endmodule

// File: rtl/corr_frame_sequencer.sv
// Joins sig1/sig2 sample sources, frames sig2 with tlast every frame_len pairs,
// inserts an idle gap after each frame and stops after num_frames or on request.
module corr_frame_sequencer import corr_pkg::*; #(
  parameter int DATA_W     = DATA_W_DEF,
  parameter int CNT_W      = CNT_W_DEF,
  parameter int GAP_CYCLES = 16
) (
  input  logic              sclk,
  input  logic              areset,
  input  logic              start,
  input  logic              stop,
  input  logic [CNT_W-1:0]  frame_len,
  input  logic [CNT_W-1:0]  num_frames,
  input  logic [DATA_W-1:0] s1_axis_tdata,
  input  logic              s1_axis_tvalid,
  output logic              s1_axis_tready,
  input  logic [DATA_W-1:0] s2_axis_tdata,
  input  logic              s2_axis_tvalid,
  output logic              s2_axis_tready,
  output logic [DATA_W-1:0] sig1_axis_tdata,
  output logic              sig1_axis_tvalid,
  input  logic              sig1_axis_tready,
  output logic [DATA_W-1:0] sig2_axis_tdata,
  output logic              sig2_axis_tvalid,
  output logic              sig2_axis_tlast,
  input  logic              sig2_axis_tready,
  output logic              busy,
  output logic              done,
  output logic              len_err,
  output logic [CNT_W-1:0]  frame_cnt
);

  localparam int GAP_W = (GAP_CYCLES < 2) ? 1 : $clog2(GAP_CYCLES);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  state_t             state;
  state_t             state_next;
  logic [CNT_W-1:0]   len_reg;
  logic [CNT_W-1:0]   num_reg;
  logic [CNT_W-1:0]   sample_idx_reg;
  logic [CNT_W-1:0]   frame_cnt_reg;
  logic [CNT_W-1:0]   frame_cnt_inc;
  logic [GAP_W-1:0]   gap_cnt_reg;
  logic               stop_pend_reg;
  logic               done_reg;
  logic               len_err_reg;
  logic               run_en;
  logic               src_ready;
  logic               load;
  logic               last_pair;
  logic               slot_free;
  logic               slot_empty;
  logic               stop_eff;
  logic               end_after_load;
  logic               end_now;

  assign src_ready      = run_en && s1_axis_tvalid && s2_axis_tvalid && slot_free;
  assign load           = src_ready;
  assign s1_axis_tready = src_ready;
  assign s2_axis_tready = src_ready;

  assign last_pair      = (sample_idx_reg == len_reg - CNT_W'(1));
  assign frame_cnt_inc  = (&frame_cnt_reg) ? frame_cnt_reg : frame_cnt_reg + CNT_W'(1);
  // A stop arriving in the very cycle of the end check still counts.
  assign stop_eff       = stop_pend_reg || stop;
  assign end_after_load = stop_eff || ((num_reg != '0) && (frame_cnt_inc == num_reg));
  assign end_now        = stop_eff || ((num_reg != '0) && (frame_cnt_reg == num_reg));

  corr_pair_slot #(.DATA_W(DATA_W)) u_slot (
    .clk        (sclk),
    .rst        (areset),
    .load       (load),
    .load_data1 (s1_axis_tdata),
    .load_data2 (s2_axis_tdata),
    .load_last  (last_pair),
    .ready1     (sig1_axis_tready),
    .ready2     (sig2_axis_tready),
    .data1      (sig1_axis_tdata),
    .valid1     (sig1_axis_tvalid),
    .data2      (sig2_axis_tdata),
    .valid2     (sig2_axis_tvalid),
    .last       (sig2_axis_tlast),
    .free       (slot_free),
    .empty      (slot_empty)
  );

  always_ff @(posedge sclk or posedge areset) begin
    if (areset) state <= ST_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (start && (frame_len != '0)) state_next = ST_RUN;
      ST_RUN: begin
        if (load && last_pair) begin
          if (GAP_CYCLES == 0) state_next = end_after_load ? ST_IDLE : ST_RUN;
          else                 state_next = ST_GAP;
        end
      end
      ST_GAP: if (slot_empty && (gap_cnt_reg == GAP_LAST)) state_next = end_now ? ST_IDLE : ST_RUN;
      default: state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    busy   = 1'b0;
    run_en = 1'b0;
    case (state)
      ST_RUN: begin
        busy   = 1'b1;
        run_en = 1'b1;
      end
      ST_GAP:  busy = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge sclk or posedge areset) begin
    if (areset) begin
      len_reg        <= '0;
      num_reg        <= '0;
      sample_idx_reg <= '0;
      frame_cnt_reg  <= '0;
      gap_cnt_reg    <= '0;
      stop_pend_reg  <= 1'b0;
      done_reg       <= 1'b0;
      len_err_reg    <= 1'b0;
    end else begin
      done_reg    <= (state != ST_IDLE) && (state_next == ST_IDLE);
      len_err_reg <= (state == ST_IDLE) && start && (frame_len == '0);
      if (state == ST_IDLE) begin
        if (start && (frame_len != '0)) begin
          len_reg        <= frame_len;
          num_reg        <= num_frames;
          sample_idx_reg <= '0;
          frame_cnt_reg  <= '0;
          stop_pend_reg  <= 1'b0;
        end
      end else begin
        if (stop) stop_pend_reg <= 1'b1;
        if (load) begin
          if (last_pair) begin
            sample_idx_reg <= '0;
            frame_cnt_reg  <= frame_cnt_inc;
          end else begin
            sample_idx_reg <= sample_idx_reg + CNT_W'(1);
          end
        end
      end
      // Gap cycles only start counting once the last pair has left the slot.
      if (state != ST_GAP)  gap_cnt_reg <= '0;
      else if (slot_empty)  gap_cnt_reg <= gap_cnt_reg + GAP_W'(1);
    end
  end

  assign done      = done_reg;
  assign len_err   = len_err_reg;
  assign frame_cnt = frame_cnt_reg;

endmodule

// File: tb/tb_corr_frame_sequencer.sv
// Randomized bench for corr_frame_sequencer: a queue-based pair scoreboard and
// run-level model are checked against the DUT on every falling clock edge.
module tb_corr_frame_sequencer;

  localparam int DW  = 16;
  localparam int CW  = 16;
  localparam int GAP = 3;

  logic          sclk = 1'b0;
  logic          areset;
  logic          start, stop;
  logic [CW-1:0] frame_len, num_frames;
  logic [DW-1:0] s1_axis_tdata, s2_axis_tdata;
  logic          s1_axis_tvalid, s1_axis_tready, s2_axis_tvalid, s2_axis_tready;
  logic [DW-1:0] sig1_axis_tdata, sig2_axis_tdata;
  logic          sig1_axis_tvalid, sig1_axis_tready;
  logic          sig2_axis_tvalid, sig2_axis_tlast, sig2_axis_tready;
  logic          busy, done, len_err;
  logic [CW-1:0] frame_cnt;

  corr_frame_sequencer #(.DATA_W(DW), .CNT_W(CW), .GAP_CYCLES(GAP)) dut (
    .sclk(sclk), .areset(areset), .start(start), .stop(stop),
    .frame_len(frame_len), .num_frames(num_frames),
    .s1_axis_tdata(s1_axis_tdata), .s1_axis_tvalid(s1_axis_tvalid), .s1_axis_tready(s1_axis_tready),
    .s2_axis_tdata(s2_axis_tdata), .s2_axis_tvalid(s2_axis_tvalid), .s2_axis_tready(s2_axis_tready),
    .sig1_axis_tdata(sig1_axis_tdata), .sig1_axis_tvalid(sig1_axis_tvalid), .sig1_axis_tready(sig1_axis_tready),
    .sig2_axis_tdata(sig2_axis_tdata), .sig2_axis_tvalid(sig2_axis_tvalid), .sig2_axis_tlast(sig2_axis_tlast),
    .sig2_axis_tready(sig2_axis_tready),
    .busy(busy), .done(done), .len_err(len_err), .frame_cnt(frame_cnt)
  );

  always #5 sclk = ~sclk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // Reference model state
  logic [DW-1:0] q1[$];
  logic [DW:0]   q2[$];
  bit  model_run, stop_issued, lenerr_pend, track, hold1, hold2, s1_taken, s2_taken;
  int  len_q, num_q, model_frames, run_pairs, frames_at_stop, gap_idle;
  int  done_cnt, lenerr_cnt, pairs_out, tlast_out;
  logic [DW-1:0] hold1_data;
  logic [DW:0]   hold2_data;

  task automatic reset_model();
    q1.delete(); q2.delete();
    model_run = 0; stop_issued = 0; lenerr_pend = 0; track = 0;
    hold1 = 0; hold2 = 0; s1_taken = 0; s2_taken = 0;
    model_frames = 0; run_pairs = 0; gap_idle = 0;
  endtask

  always @(negedge sclk) begin
    if (areset) begin
      hold1 = 0; hold2 = 0; s1_taken = 0; s2_taken = 0;
    end else begin
      if (done) begin
        chk("done_in_run", model_run, 1);
        chk("done_busy_low", busy, 0);
        chk("done_drained", q1.size() + q2.size(), 0);
        chk("done_frame_boundary", run_pairs % len_q, 0);
        if (stop_issued) begin
          chk("stop_frames", (model_frames == frames_at_stop) || (model_frames == frames_at_stop + 1), 1);
          if (num_q != 0) chk("stop_frames_max", model_frames <= num_q, 1);
        end else begin
          chk("done_frames", model_frames, num_q);
        end
        done_cnt++;
        model_run = 0;
        track = 0;
      end
      chk("busy", busy, model_run);
      chk("len_err", len_err, lenerr_pend);
      if (len_err) lenerr_cnt++;
      lenerr_pend = 0;
      chk("frame_cnt", frame_cnt, model_frames);
      chk("ready_lockstep", s1_axis_tready, s2_axis_tready);
      if (s1_axis_tready) chk("ready_cond", {s1_axis_tvalid, s2_axis_tvalid, model_run}, 3'b111);
      if ((sig1_axis_tvalid && !sig1_axis_tready) || (sig2_axis_tvalid && !sig2_axis_tready))
        chk("no_load_on_hold", s1_axis_tready, 0);
      if (hold1) chk("sig1_stable", {sig1_axis_tvalid, sig1_axis_tdata}, {1'b1, hold1_data});
      if (hold2) chk("sig2_stable", {sig2_axis_tvalid, sig2_axis_tlast, sig2_axis_tdata}, {1'b1, hold2_data});
      if (track) begin
        if (sig2_axis_tvalid) begin
          chk("gap_len", gap_idle >= GAP, 1);
          track = 0;
        end else begin
          gap_idle++;
        end
      end
      // Output handshakes consume the oldest expected pair before any new load.
      if (sig1_axis_tvalid && sig1_axis_tready) begin
        if (q1.size() == 0) chk("sig1_underflow", 1, 0);
        else chk("sig1_data", sig1_axis_tdata, q1.pop_front());
      end
      if (sig2_axis_tvalid && sig2_axis_tready) begin
        if (q2.size() == 0) chk("sig2_underflow", 1, 0);
        else chk("sig2_pair", {sig2_axis_tlast, sig2_axis_tdata}, q2.pop_front());
        pairs_out++;
        if (sig2_axis_tlast) begin
          tlast_out++;
          track = 1;
          gap_idle = 0;
        end
      end
      if (stop && model_run && !stop_issued) begin
        stop_issued = 1;
        frames_at_stop = model_frames;
      end
      s1_taken = s1_axis_tready && s1_axis_tvalid;
      s2_taken = s2_axis_tready && s2_axis_tvalid;
      if (s1_taken && s2_taken) begin
        bit is_last;
        is_last = (run_pairs % len_q) == (len_q - 1);
        q1.push_back(s1_axis_tdata);
        q2.push_back({is_last, s2_axis_tdata});
        run_pairs++;
        if (is_last) model_frames++;
      end
      if (start && !model_run) begin
        if (frame_len == 0) lenerr_pend = 1;
        else begin
          model_run = 1; stop_issued = 0;
          len_q = int'(frame_len); num_q = int'(num_frames);
          model_frames = 0; run_pairs = 0;
        end
      end
      hold1 = sig1_axis_tvalid && !sig1_axis_tready;
      hold1_data = sig1_axis_tdata;
      hold2 = sig2_axis_tvalid && !sig2_axis_tready;
      hold2_data = {sig2_axis_tlast, sig2_axis_tdata};
    end
  end

  task automatic run_test(input int len, input int num, input int stop_after,
                          input int pv1, input int pv2, input int pr1, input int pr2,
                          input int skew_at, input int bp_at, input bit stop_with_start);
    int cyc;
    bit stop_sent;
    done_cnt = 0; pairs_out = 0; tlast_out = 0; stop_sent = 0;
    frame_len = CW'(len); num_frames = CW'(num);
    start = 1; stop = stop_with_start;
    @(posedge sclk); #1;
    start = 0; stop = 0;
    cyc = 0;
    while (done_cnt == 0 && cyc < 4000) begin
      if (!s1_axis_tvalid || s1_taken) begin
        s1_axis_tvalid = ($urandom_range(99) < pv1);
        s1_axis_tdata  = DW'($urandom);
      end
      if (!s2_axis_tvalid || s2_taken) begin
        s2_axis_tvalid = ($urandom_range(99) < pv2);
        s2_axis_tdata  = DW'($urandom);
      end
      if (cyc >= skew_at && cyc < skew_at + 5) s2_axis_tvalid = 0;
      sig1_axis_tready = ($urandom_range(99) < pr1);
      sig2_axis_tready = ($urandom_range(99) < pr2);
      if (cyc >= bp_at && cyc < bp_at + 3) begin
        sig1_axis_tready = 0;
        sig2_axis_tready = 1;
      end
      stop = 0;
      if (stop_after > 0 && !stop_sent && run_pairs >= stop_after) begin
        stop = 1;
        stop_sent = 1;
      end
      @(posedge sclk); #1;
      cyc++;
    end
    chk("run_timeout", cyc < 4000, 1);
    stop = 0; s1_axis_tvalid = 0; s2_axis_tvalid = 0;
    sig1_axis_tready = 1; sig2_axis_tready = 1;
    repeat (3) @(posedge sclk);
    #1;
    if (!stop_sent) chk("pairs_total", pairs_out, len * num);
    chk("done_count", done_cnt, 1);
    chk("busy_after", busy, 0);
    $display("run len=%0d num=%0d stop_after=%0d: pairs=%0d tlasts=%0d frame_cnt=%0d cycles=%0d",
             len, num, stop_after, pairs_out, tlast_out, frame_cnt, cyc);
  endtask

  initial begin
    areset = 1; start = 0; stop = 0; frame_len = '0; num_frames = '0;
    s1_axis_tdata = '0; s2_axis_tdata = '0; s1_axis_tvalid = 0; s2_axis_tvalid = 0;
    sig1_axis_tready = 0; sig2_axis_tready = 0;
    reset_model(); done_cnt = 0; lenerr_cnt = 0;
    repeat (3) @(posedge sclk);
    #1 areset = 0;
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_len_err", len_err, 0);
    chk("rst_frame_cnt", frame_cnt, 0);
    chk("rst_valids", {sig1_axis_tvalid, sig2_axis_tvalid, sig2_axis_tlast}, 3'b000);
    chk("rst_treadys", {s1_axis_tready, s2_axis_tready}, 2'b00);
    @(posedge sclk); #1;

    // Basic frame: 8 pairs, tlast on 4 and 8, one done.
    run_test(4, 2, 0, 100, 100, 100, 100, -10, -10, 0);
    chk("basic_pairs", pairs_out, 8);
    chk("basic_tlasts", tlast_out, 2);
    chk("basic_frame_cnt", frame_cnt, 2);

    // Skewed sources: sig2 source withheld for 5 cycles mid-frame.
    run_test(6, 2, 0, 100, 100, 100, 100, 3, -10, 0);
    chk("skew_pairs", pairs_out, 12);

    // sig1 sink stalled for 3 cycles while sig2 sink stays ready.
    run_test(5, 1, 0, 100, 100, 100, 100, -10, 2, 0);
    chk("bp_pairs", pairs_out, 5);

    // Stop mid-frame in continuous mode.
    run_test(10, 0, 3, 100, 100, 100, 100, -10, -10, 0);
    chk("stop_pairs", pairs_out, 10);
    chk("stop_frame_cnt", frame_cnt, 1);
    chk("stop_tlasts", tlast_out, 1);

    // Zero length start.
    lenerr_cnt = 0;
    s1_axis_tvalid = 1; s2_axis_tvalid = 1;
    frame_len = '0; num_frames = CW'(1); start = 1;
    @(posedge sclk); #1 start = 0;
    repeat (4) @(posedge sclk);
    #1;
    chk("zero_len_err_pulses", lenerr_cnt, 1);
    chk("zero_len_busy", busy, 0);
    s1_axis_tvalid = 0; s2_axis_tvalid = 0;
    $display("zero-length start: len_err pulses=%0d", lenerr_cnt);

    // Async reset with a held pair, then a fresh run.
    sig1_axis_tready = 0; sig2_axis_tready = 0;
    s1_axis_tvalid = 1; s2_axis_tvalid = 1;
    frame_len = CW'(8); num_frames = '0; start = 1;
    @(posedge sclk); #1 start = 0;
    repeat (4) @(posedge sclk);
    #1;
    chk("held_before_reset", {sig1_axis_tvalid, sig2_axis_tvalid, busy}, 3'b111);
    #1 areset = 1;
    #1;
    chk("areset_outputs", {sig1_axis_tvalid, sig2_axis_tvalid, sig2_axis_tlast, busy, s1_axis_tready}, 5'b00000);
    reset_model();
    s1_axis_tvalid = 0; s2_axis_tvalid = 0;
    sig1_axis_tready = 1; sig2_axis_tready = 1;
    @(posedge sclk); #1 areset = 0;
    $display("async reset with held pair applied");
    @(posedge sclk); #1;
    run_test(3, 2, 0, 100, 100, 100, 100, -10, -10, 0);
    chk("post_reset_frame_cnt", frame_cnt, 2);

    // Randomized runs with random valid/ready rates, stops and start+stop.
    for (int i = 0; i < 12; i++) begin
      int len, num, sa;
      len = $urandom_range(7, 1);
      num = $urandom_range(4, 1);
      sa  = ($urandom_range(3) == 0) ? $urandom_range(len * num, 1) : 0;
      run_test(len, num, sa, $urandom_range(100, 40), $urandom_range(100, 40),
               $urandom_range(100, 40), $urandom_range(100, 40),
               $urandom_range(20), $urandom_range(20), 1'($urandom_range(1)));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
